// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM encodings and block geometry for the instruction cache
package icache_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;
  localparam int BLOCK_BYTES = 16;
  localparam int OFF_W = 4;
endpackage

// File: rtl/icache_tag_array.sv
// icache_tag_array: per-line valid/tag storage with combinational hit compare; valid cleared on reset
module icache_tag_array #(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W = 3,
  parameter int TAG_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] index,
  input  logic [TAG_W-1:0] tag,
  input  logic             write,
  output logic             hit
);
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q [NUM_BLOCKS];
  always_ff @(posedge clock)
    if (reset) valid_q <= '0;
    else if (write) valid_q[index] <= 1'b1;
  always_ff @(posedge clock)
    if (write) tag_q[index] <= tag;
  assign hit = valid_q[index] && tag_q[index] == tag;
endmodule

// File: rtl/icache_controller.sv
// icache_controller: direct-mapped instruction cache with block fill FSM
// ICACHE_STATS_EN adds saturating hit_count/miss_count outputs
module icache_controller
  import icache_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int NUM_BLOCKS = 8
) (
  input  logic                clock,
  input  logic                reset,
`ifdef ICACHE_STATS_EN
  output logic [15:0]         hit_count,
  output logic [15:0]         miss_count,
`endif
  input  logic                read,
  input  logic [ADDR_W-1:0]   address,
  output logic [31:0]         instruction,
  output logic                busywait,
  output logic                mem_read,
  output logic [ADDR_W-5:0]   mem_address,
  input  logic [127:0]        mem_readdata,
  input  logic                mem_busywait
);
  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  state_t           state, state_n;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] index;
  logic [1:0]       word;
  logic             hit, fill, unused;
  logic [127:0]     data_q [NUM_BLOCKS];
  assign tag    = address[ADDR_W-1 -: TAG_W];
  assign index  = address[OFF_W +: IDX_W];
  assign word   = address[3:2];
  assign unused = ^address[1:0];
  // A reset landing on UPDATE must not commit the block
  assign fill   = state == UPDATE && !reset;
  icache_tag_array #(.NUM_BLOCKS(NUM_BLOCKS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_tags (
    .clock (clock),
    .reset (reset),
    .index (index),
    .tag   (tag),
    .write (fill),
    .hit   (hit)
  );
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_n;
  always_comb
    state_n = state == IDLE     ? (read && !hit ? MEM_READ : IDLE) :
              state == MEM_READ ? (mem_busywait ? MEM_READ : UPDATE) : IDLE;
  always_comb begin
    mem_read    = state == MEM_READ;
    mem_address = {tag, index};
    busywait    = read && !(state == IDLE && hit);
    instruction = data_q[index][{word, 5'b0} +: 32];
  end
  always_ff @(posedge clock)
    if (fill) data_q[index] <= mem_readdata;
`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock)
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == IDLE && read && hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (state == IDLE && read && !hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
`endif
endmodule
